// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue controller.
// Accumulator feature is enabled by defining ALU_ISSUE_ACC_EN.
package alu_issue_pkg;

  localparam int unsigned OP_W = 2;

  localparam logic [OP_W-1:0] OP_ADD    = 2'd0;
  localparam logic [OP_W-1:0] OP_SUB    = 2'd1;
  localparam logic [OP_W-1:0] OP_PASS_A = 2'd2;
  localparam logic [OP_W-1:0] OP_PASS_B = 2'd3;

  localparam logic [7:0] ACC_RESET = 8'hAB;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_issue_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two so pointers wrap naturally.
module alu_issue_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Pushes are refused when full even if a pop happens in the same cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command-side controller for the 4-opcode ALU: FIFO, issue FSM, response channel.
// Define ALU_ISSUE_ACC_EN to add the io_acc running accumulator.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               io_cmd_valid,
  output logic               io_cmd_ready,
  input  logic [OP_W-1:0]    io_cmd_opcode,
  input  logic [WIDTH-1:0]   io_cmd_a,
  input  logic [WIDTH-1:0]   io_cmd_b,
  output logic [OP_W-1:0]    io_alu_opcode,
  output logic [WIDTH-1:0]   io_alu_a,
  output logic [WIDTH-1:0]   io_alu_b,
  input  logic [WIDTH-1:0]   io_alu_out,
  output logic               io_rsp_valid,
  input  logic               io_rsp_ready,
  output logic [WIDTH-1:0]   io_rsp_data,
  output logic [OP_W-1:0]    io_rsp_opcode,
  output logic               io_busy
`ifdef ALU_ISSUE_ACC_EN
  ,
  output logic [2*WIDTH-1:0] io_acc
`endif
);

  localparam int unsigned ENT_W = OP_W + 2 * WIDTH;
  localparam int unsigned ACC_W = 2 * WIDTH;

  state_t             r_state;
  logic [OP_W-1:0]    r_alu_opcode;
  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;
  logic               r_rsp_valid;
  logic [WIDTH-1:0]   r_rsp_data;
  logic [OP_W-1:0]    r_rsp_opcode;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic [ENT_W-1:0]   w_cmd;
  logic [ENT_W-1:0]   w_head;

  assign w_cmd = {io_cmd_opcode, io_cmd_a, io_cmd_b};
  assign w_pop = (r_state == ST_IDLE);

  alu_issue_fifo #(
    .DEPTH (DEPTH),
    .DW    (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (io_cmd_valid),
    .i_pop   (w_pop),
    .i_data  (w_cmd),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Issue FSM: pop into operand registers, capture ALU result, hold until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_alu_opcode <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_opcode <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            {r_alu_opcode, r_alu_a, r_alu_b} <= w_head;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_rsp_data   <= io_alu_out;
          r_rsp_opcode <= r_alu_opcode;
          r_rsp_valid  <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (io_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_cmd_ready  = !w_full;
  assign io_alu_opcode = r_alu_opcode;
  assign io_alu_a      = r_alu_a;
  assign io_alu_b      = r_alu_b;
  assign io_rsp_valid  = r_rsp_valid;
  assign io_rsp_data   = r_rsp_data;
  assign io_rsp_opcode = r_rsp_opcode;
  assign io_busy       = !w_empty || (r_state != ST_IDLE);

`ifdef ALU_ISSUE_ACC_EN
  logic [ACC_W-1:0] r_acc;

  // Running total of accepted results, wrapping at 2*WIDTH bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= ACC_W'(ACC_RESET);
    end else if (r_rsp_valid && io_rsp_ready) begin
      r_acc <= r_acc + ACC_W'(r_rsp_data);
    end
  end

  assign io_acc = r_acc;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: vector table, directed corner cases, random traffic vs. scoreboard.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       io_cmd_valid = 1'b0;
  logic       io_cmd_ready;
  logic [1:0] io_cmd_opcode = '0;
  logic [3:0] io_cmd_a = '0;
  logic [3:0] io_cmd_b = '0;
  logic [1:0] io_alu_opcode;
  logic [3:0] io_alu_a;
  logic [3:0] io_alu_b;
  logic [3:0] io_alu_out;
  logic       io_rsp_valid;
  logic       io_rsp_ready = 1'b0;
  logic [3:0] io_rsp_data;
  logic [1:0] io_rsp_opcode;
  logic       io_busy;
`ifdef ALU_ISSUE_ACC_EN
  logic [7:0] io_acc;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_rsp = 0;

  typedef struct {
    logic [1:0] op;
    logic [3:0] d;
  } rsp_t;
  rsp_t exp_q[$];
  logic [7:0] m_acc = 8'hAB;

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_data;
    logic [7:0] exp_acc;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_f(logic [1:0] op, logic [3:0] a, logic [3:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a;
      default: return b;
    endcase
  endfunction

  // Environment ALU driven by the DUT's operand registers.
  assign io_alu_out = alu_f(io_alu_opcode, io_alu_a, io_alu_b);

  alu_issue_ctrl #(.DEPTH(4), .WIDTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .io_cmd_valid  (io_cmd_valid),
    .io_cmd_ready  (io_cmd_ready),
    .io_cmd_opcode (io_cmd_opcode),
    .io_cmd_a      (io_cmd_a),
    .io_cmd_b      (io_cmd_b),
    .io_alu_opcode (io_alu_opcode),
    .io_alu_a      (io_alu_a),
    .io_alu_b      (io_alu_b),
    .io_alu_out    (io_alu_out),
    .io_rsp_valid  (io_rsp_valid),
    .io_rsp_ready  (io_rsp_ready),
    .io_rsp_data   (io_rsp_data),
    .io_rsp_opcode (io_rsp_opcode),
    .io_busy       (io_busy)
`ifdef ALU_ISSUE_ACC_EN
    ,
    .io_acc        (io_acc)
`endif
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [1:0] op, logic [3:0] a, logic [3:0] b);
    io_cmd_valid  = 1'b1;
    io_cmd_opcode = op;
    io_cmd_a      = a;
    io_cmd_b      = b;
  endtask

  task automatic do_reset();
    io_cmd_valid = 1'b0;
    io_rsp_ready = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_rsp(string nm, int target, int budget);
    for (int i = 0; i < budget && n_rsp < target; i++) step();
    chk(nm, 32'(n_rsp), 32'(target));
  endtask

  // Scoreboard: in-order expected results, hold stability and accumulator model.
  logic       have_prev = 1'b0;
  logic [3:0] prev_d;
  logic [1:0] prev_op;
  always @(negedge clk) begin
    rsp_t e;
    if (!rst_n) begin
      exp_q.delete();
      m_acc = 8'hAB;
      have_prev = 1'b0;
    end else begin
`ifdef ALU_ISSUE_ACC_EN
      chk("acc_track", 32'(io_acc), 32'(m_acc));
`endif
      if (have_prev) begin
        chk("hold_valid", 32'(io_rsp_valid), 32'd1);
        chk("hold_data", 32'(io_rsp_data), 32'(prev_d));
        chk("hold_op", 32'(io_rsp_opcode), 32'(prev_op));
      end
      have_prev = io_rsp_valid && !io_rsp_ready;
      prev_d    = io_rsp_data;
      prev_op   = io_rsp_opcode;
      if (io_rsp_valid && io_rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", 32'(io_rsp_data), 32'(e.d));
          chk("sb_op", 32'(io_rsp_opcode), 32'(e.op));
        end
        m_acc = m_acc + {4'b0, io_rsp_data};
        n_rsp++;
      end
      if (io_cmd_valid && io_cmd_ready) begin
        e.op = io_cmd_opcode;
        e.d  = alu_f(io_cmd_opcode, io_cmd_a, io_cmd_b);
        exp_q.push_back(e);
      end
    end
  end

  initial begin
    int base;
    int sent;
    vecs[0] = '{op: 2'd0, a: 4'd3,  b: 4'd4,  exp_data: 4'd7,  exp_acc: 8'hB2};
    vecs[1] = '{op: 2'd1, a: 4'd2,  b: 4'd5,  exp_data: 4'hD,  exp_acc: 8'hBF};
    vecs[2] = '{op: 2'd3, a: 4'd1,  b: 4'd9,  exp_data: 4'd9,  exp_acc: 8'hC8};
    vecs[3] = '{op: 2'd2, a: 4'd6,  b: 4'd0,  exp_data: 4'd6,  exp_acc: 8'hCE};
    vecs[4] = '{op: 2'd0, a: 4'hF,  b: 4'hF,  exp_data: 4'hE,  exp_acc: 8'hDC};
    vecs[5] = '{op: 2'd1, a: 4'd0,  b: 4'd1,  exp_data: 4'hF,  exp_acc: 8'hEB};

    // Reset values before any clock edge
    #2;
    chk("rst_cmd_ready", 32'(io_cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(io_rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(io_rsp_data), 32'd0);
    chk("rst_rsp_op", 32'(io_rsp_opcode), 32'd0);
    chk("rst_alu", 32'({io_alu_opcode, io_alu_a, io_alu_b}), 32'd0);
    chk("rst_busy", 32'(io_busy), 32'd0);
`ifdef ALU_ISSUE_ACC_EN
    chk("rst_acc", 32'(io_acc), 32'hAB);
`endif
    do_reset();

    // Single-command latency and result table
    for (int i = 0; i < 6; i++) begin
      io_rsp_ready = 1'b1;
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_cmd_ready", i), 32'(io_cmd_ready), 32'd1);
      step();
      io_cmd_valid = 1'b0;
      chk($sformatf("v%0d_n_valid", i), 32'(io_rsp_valid), 32'd0);
      chk($sformatf("v%0d_n_busy", i), 32'(io_busy), 32'd1);
      step();
      chk($sformatf("v%0d_alu", i), 32'({io_alu_opcode, io_alu_a, io_alu_b}),
          32'({vecs[i].op, vecs[i].a, vecs[i].b}));
      chk($sformatf("v%0d_n1_valid", i), 32'(io_rsp_valid), 32'd0);
      step();
      chk($sformatf("v%0d_n2_valid", i), 32'(io_rsp_valid), 32'd1);
      chk($sformatf("v%0d_data", i), 32'(io_rsp_data), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d_op", i), 32'(io_rsp_opcode), 32'(vecs[i].op));
      step();
      chk($sformatf("v%0d_done_valid", i), 32'(io_rsp_valid), 32'd0);
      chk($sformatf("v%0d_done_busy", i), 32'(io_busy), 32'd0);
      chk($sformatf("v%0d_alu_hold", i), 32'(io_alu_a), 32'(vecs[i].a));
`ifdef ALU_ISSUE_ACC_EN
      chk($sformatf("v%0d_acc", i), 32'(io_acc), 32'(vecs[i].exp_acc));
`endif
    end

`ifdef ALU_ISSUE_ACC_EN
    // Sixteen 4'hF results from 8'hAB wrap to 8'h9B
    do_reset();
    io_rsp_ready = 1'b1;
    base = n_rsp;
    sent = 0;
    for (int i = 0; i < 200 && sent < 16; i++) begin
      send(2'd3, 4'd0, 4'hF);
      if (io_cmd_ready) sent++;
      step();
    end
    io_cmd_valid = 1'b0;
    wait_rsp("acc_wrap_rsp", base + 16, 200);
    chk("acc_wrap", 32'(io_acc), 32'h9B);
`endif

    // Backpressure: five pushes fill the FIFO behind one issued command
    io_rsp_ready = 1'b0;
    base = n_rsp;
    for (int i = 0; i < 5; i++) begin
      send(2'(i), 4'(i), 4'(i + 1));
      chk($sformatf("bp_ready%0d", i), 32'(io_cmd_ready), 32'd1);
      step();
    end
    io_cmd_valid = 1'b0;
    chk("bp_full", 32'(io_cmd_ready), 32'd0);
    repeat (4) step();
    chk("bp_stall_valid", 32'(io_rsp_valid), 32'd1);
    chk("bp_stall_data", 32'(io_rsp_data), 32'd1);
    chk("bp_stall_full", 32'(io_cmd_ready), 32'd0);
    send(2'd0, 4'd5, 4'd5);
    io_rsp_ready = 1'b1;
    step();
    chk("bp_no_bypass", 32'(io_cmd_ready), 32'd0);
    step();
    chk("bp_after_pop", 32'(io_cmd_ready), 32'd1);
    step();
    io_cmd_valid = 1'b0;
    wait_rsp("bp_drain", base + 6, 80);

    // Simultaneous push/pop at count 2 keeps count at 2
    io_rsp_ready = 1'b0;
    base = n_rsp;
    for (int i = 0; i < 3; i++) begin
      send(2'd0, 4'(i), 4'd8);
      step();
    end
    io_cmd_valid = 1'b0;
    step();
    chk("pp_resp", 32'(io_rsp_valid), 32'd1);
    io_rsp_ready = 1'b1;
    step();
    io_rsp_ready = 1'b0;
    send(2'd1, 4'd9, 4'd3);
    step();
    send(2'd2, 4'd4, 4'd0);
    chk("pp_ready_a", 32'(io_cmd_ready), 32'd1);
    step();
    send(2'd3, 4'd0, 4'd2);
    chk("pp_ready_b", 32'(io_cmd_ready), 32'd1);
    step();
    io_cmd_valid = 1'b0;
    chk("pp_full", 32'(io_cmd_ready), 32'd0);
    io_rsp_ready = 1'b1;
    wait_rsp("pp_drain", base + 6, 80);

    // Random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      io_cmd_valid  = 1'($urandom_range(0, 1));
      io_cmd_opcode = 2'($urandom_range(0, 3));
      io_cmd_a      = 4'($urandom_range(0, 15));
      io_cmd_b      = 4'($urandom_range(0, 15));
      io_rsp_ready  = ($urandom_range(0, 9) < 6);
      step();
    end
    io_cmd_valid = 1'b0;
    io_rsp_ready = 1'b1;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || io_busy); i++) step();
    chk("rand_drain_q", 32'(exp_q.size()), 32'd0);
    chk("rand_drain_busy", 32'(io_busy), 32'd0);

    // Reset while a response is pending and another command is queued
    io_rsp_ready = 1'b0;
    send(2'd0, 4'd1, 4'd1);
    step();
    send(2'd0, 4'd2, 4'd2);
    step();
    io_cmd_valid = 1'b0;
    step();
    step();
    chk("mr_pre_valid", 32'(io_rsp_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(io_rsp_valid), 32'd0);
    chk("mr_busy", 32'(io_busy), 32'd0);
    chk("mr_ready", 32'(io_cmd_ready), 32'd1);
    chk("mr_data", 32'(io_rsp_data), 32'd0);
    chk("mr_alu", 32'({io_alu_opcode, io_alu_a, io_alu_b}), 32'd0);
`ifdef ALU_ISSUE_ACC_EN
    chk("mr_acc", 32'(io_acc), 32'hAB);
`endif
    step();
    rst_n = 1'b1;
    io_rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("mr_stale%0d", i), 32'(io_rsp_valid), 32'd0);
    end
    chk("mr_idle_busy", 32'(io_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
